// File: rtl/rggen_register_bus_arbiter_pkg.sv
// rggen_register_bus_arbiter_pkg: shared register-bus codes, state type and sizing helper
package rggen_register_bus_arbiter_pkg;
  localparam logic [1:0] STATUS_OKAY = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY = 2'b01;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_DECERR = 2'b11;
  localparam logic [1:0] ACCESS_IDLE = 2'b00;
  localparam logic [1:0] ACCESS_READ = 2'b10;
  localparam logic [1:0] ACCESS_WRITE = 2'b11;
  typedef enum logic {IDLE, BUSY} state_e;
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rggen_round_robin_selector.sv
// rggen_round_robin_selector: first active request at or after ptr, wrapping modulo N
module rggen_round_robin_selector
  import rggen_register_bus_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found
);
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && request[(int'(ptr) + i) % N]) begin
        grant[(int'(ptr) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rggen_register_bus_arbiter.sv
// rggen_register_bus_arbiter: round-robin sharing of one register-bus slave port
// between N requesters, one outstanding transaction at a time.
module rggen_register_bus_arbiter
  import rggen_register_bus_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [REQUESTERS-1:0]           i_request_valid,
  input  logic [2*REQUESTERS-1:0]         i_request_access,
  input  logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_request_address,
  input  logic [BUS_WIDTH*REQUESTERS-1:0] i_request_write_data,
  input  logic [BUS_WIDTH*REQUESTERS-1:0] i_request_strobe,
  output logic [REQUESTERS-1:0]           o_request_ready,
  output logic [2*REQUESTERS-1:0]         o_request_status,
  output logic [BUS_WIDTH*REQUESTERS-1:0] o_request_read_data,
  output logic [REQUESTERS-1:0]           o_grant,
  output logic                            o_register_valid,
  output logic [1:0]                      o_register_access,
  output logic [ADDRESS_WIDTH-1:0]        o_register_address,
  output logic [BUS_WIDTH-1:0]            o_register_write_data,
  output logic [BUS_WIDTH-1:0]            o_register_strobe,
  input  logic                            i_register_ready,
  input  logic [1:0]                      i_register_status,
  input  logic [BUS_WIDTH-1:0]            i_register_read_data
);
  localparam int N = REQUESTERS;
  localparam int PW = ptr_width(N);
  state_e state;
  logic [N-1:0] grant;
  logic [N-1:0] next_grant;
  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic found;
  logic done;
  rggen_round_robin_selector #(.N(N), .PW(PW)) u_selector (
    .request (i_request_valid),
    .ptr     (ptr),
    .grant   (next_grant),
    .found   (found)
  );
  // priority moves to the requester just after the one that completed
  always_comb begin
    next_ptr = '0;
    for (int i = 0; i < N; i++) if (grant[i]) next_ptr = PW'((i + 1) % N);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= BUSY;
        grant <= next_grant;
      end
    end else if (i_register_ready) begin
      state <= IDLE;
      grant <= '0;
      ptr <= next_ptr;
    end
  end
  // grant is one-hot or zero, so OR-ing the selected slots is a plain mux
  always_comb begin
    o_register_access = '0;
    o_register_address = '0;
    o_register_write_data = '0;
    o_register_strobe = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        o_register_access = o_register_access | i_request_access[2*i+:2];
        o_register_address = o_register_address | i_request_address[ADDRESS_WIDTH*i+:ADDRESS_WIDTH];
        o_register_write_data = o_register_write_data | i_request_write_data[BUS_WIDTH*i+:BUS_WIDTH];
        o_register_strobe = o_register_strobe | i_request_strobe[BUS_WIDTH*i+:BUS_WIDTH];
      end
    end
  end
  assign done = (state == BUSY) && i_register_ready;
  assign o_register_valid = state == BUSY;
  assign o_grant = grant;
  assign o_request_ready = grant & {N{done}};
  for (genvar g = 0; g < N; g++) begin : g_resp
    assign o_request_status[2*g+:2] = o_request_ready[g] ? i_register_status : 2'b00;
    assign o_request_read_data[BUS_WIDTH*g+:BUS_WIDTH] = o_request_ready[g] ? i_register_read_data : '0;
  end
endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// tb_rggen_register_bus_arbiter: owner/pointer model check of a 2-requester arbiter
// plus directed literal checks, including a 4-requester instance.
module tb_rggen_register_bus_arbiter;
  import rggen_register_bus_arbiter_pkg::*;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] valid, rdy, gnt, ra, rs;
  logic [3:0] acc, st;
  logic [15:0] addr;
  logic [63:0] wd, strb, rd;
  logic rv, rr;
  logic [7:0] raddr;
  logic [31:0] rwd, rstb, rrd;
  logic [3:0] valid_b, rdy_b, gnt_b;
  logic [7:0] acc_b, st_b;
  logic [31:0] addr_b;
  logic [127:0] wd_b, strb_b, rd_b;
  logic rv_b, rr_b;
  logic [1:0] ra_b, rs_b;
  logic [7:0] raddr_b;
  logic [31:0] rwd_b, rstb_b, rrd_b;
  rggen_register_bus_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_request_valid(valid), .i_request_access(acc),
    .i_request_address(addr), .i_request_write_data(wd), .i_request_strobe(strb),
    .o_request_ready(rdy), .o_request_status(st), .o_request_read_data(rd), .o_grant(gnt),
    .o_register_valid(rv), .o_register_access(ra), .o_register_address(raddr),
    .o_register_write_data(rwd), .o_register_strobe(rstb), .i_register_ready(rr),
    .i_register_status(rs), .i_register_read_data(rrd)
  );
  rggen_register_bus_arbiter #(.REQUESTERS(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_request_valid(valid_b), .i_request_access(acc_b),
    .i_request_address(addr_b), .i_request_write_data(wd_b), .i_request_strobe(strb_b),
    .o_request_ready(rdy_b), .o_request_status(st_b), .o_request_read_data(rd_b), .o_grant(gnt_b),
    .o_register_valid(rv_b), .o_register_access(ra_b), .o_register_address(raddr_b),
    .o_register_write_data(rwd_b), .o_register_strobe(rstb_b), .i_register_ready(rr_b),
    .i_register_status(rs_b), .i_register_read_data(rrd_b)
  );
  int checks = 0;
  int errors = 0;
  int viol = 0;
  bit flagged = 1'b0;
  bit armed = 1'b0;
  int owner = -1;
  int mptr = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // model: who owns the bus (-1 = nobody) and who has priority next
  always @(posedge clk) begin
    if (rst) begin
      owner <= -1;
      mptr <= 0;
    end else if (owner < 0) owner <= pick(valid, mptr);
    else if (rr) begin
      mptr <= (owner + 1) % N;
      owner <= -1;
    end
  end
  always @(negedge clk) begin : cmp
    logic [1:0] eg, ea, erdy;
    logic [3:0] est;
    logic [7:0] eaddr;
    logic [31:0] ewd, estb;
    logic [63:0] erd;
    logic ev;
    if (armed) begin
      eg = '0; ea = '0; erdy = '0; est = '0; eaddr = '0; ewd = '0; estb = '0; erd = '0; ev = 1'b0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        ev = 1'b1;
        ea = acc[2*owner+:2];
        eaddr = addr[8*owner+:8];
        ewd = wd[32*owner+:32];
        estb = strb[32*owner+:32];
        if (rr) begin
          erdy[owner] = 1'b1;
          est[2*owner+:2] = rs;
          erd[32*owner+:32] = rrd;
        end
      end
      check("grant", gnt, eg);
      check("reg_valid", rv, ev);
      check("reg_access", ra, ea);
      check("reg_address", raddr, eaddr);
      check("reg_write_data", rwd, ewd);
      check("reg_strobe", rstb, estb);
      check("req_ready", rdy, erdy);
      check("req_status", st, est);
      check("req_read_data", rd, erd);
      if (owner < 0) flagged = 1'b0;
      else if (!rst && !valid[owner] && !flagged) begin
        viol++;
        flagged = 1'b1;
        $display("PROTOCOL: requester %0d dropped valid before its ready", owner);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, last, vcnt;
    valid = '0; acc = '0; addr = '0; wd = '0; strb = '0; rr = 1'b0; rs = '0; rrd = '0;
    valid_b = '0; acc_b = '0; addr_b = '0; wd_b = '0; strb_b = '0; rr_b = 1'b0; rs_b = '0; rrd_b = '0;
    step();
    step();
    armed = 1'b1;
    rst = 1'b0;
    // single read from requester 0
    valid = 2'b01; acc[1:0] = ACCESS_READ; addr[7:0] = 8'h10;
    @(negedge clk) check("t1_reset_grant", gnt, 2'b00);
    check("t1_reset_ready", rdy, 2'b00);
    step();
    @(negedge clk) check("t1_grant", gnt, 2'b01);
    step();
    rr = 1'b1; rrd = 32'h1234_5678; rs = STATUS_OKAY;
    @(negedge clk) check("t1_ready", rdy, 2'b01);
    check("t1_read_data", rd, 64'h0000_0000_1234_5678);
    step();
    rr = 1'b0; valid = '0; rrd = '0;
    // both requesters continuously valid, ready immediate
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 2'b11; addr = {8'h08, 8'h04}; acc = {ACCESS_READ, ACCESS_READ}; rr = 1'b1; rrd = 32'hCAFE_0000;
    n = 0; last = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rdy != 2'b00) begin
        check("t2_order", gnt, (n % 2 != 0) ? 2'b10 : 2'b01);
        check("t2_address", raddr, (n % 2 != 0) ? 8'h08 : 8'h04);
        if (last >= 0) check("t2_gap", c - last, 2);
        last = c;
        n++;
      end
      step();
    end
    check("t2_count", n, 4);
    valid = '0; rr = 1'b0;
    // stalled write from requester 1
    valid = 2'b10; acc[3:2] = ACCESS_WRITE; addr[15:8] = 8'h20;
    wd[63:32] = 32'hA5A5_A5A5; strb[63:32] = 32'h0000_FFFF;
    step();
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        rr = 1'b1; rs = STATUS_SLVERR;
      end
      @(negedge clk);
      if (rv) vcnt++;
      check("t3_access", ra, ACCESS_WRITE);
      check("t3_wdata", rwd, 32'hA5A5_A5A5);
      check("t3_strobe", rstb, 32'h0000_FFFF);
      if (c < 5) check("t3_no_ready", rdy, 2'b00);
      else begin
        check("t3_ready", rdy, 2'b10);
        check("t3_status", st, 4'b1000);
      end
      step();
    end
    check("t3_valid_cycles", vcnt, 6);
    rr = 1'b0; rs = '0; valid = '0;
    @(negedge clk) check("t3_idle_after", rv, 1'b0);
    // reset on the 2nd busy cycle
    valid = 2'b01;
    step();
    step();
    rst = 1'b1; valid = 2'b10;
    @(negedge clk) check("t4_busy_before_reset", gnt, 2'b01);
    step();
    rst = 1'b0;
    @(negedge clk) check("t4_grant_cleared", gnt, 2'b00);
    check("t4_valid_cleared", rv, 1'b0);
    check("t4_no_ready", rdy, 2'b00);
    step();
    rr = 1'b1;
    @(negedge clk) check("t4_regrant", gnt, 2'b10);
    check("t4_ready", rdy, 2'b10);
    step();
    rr = 1'b0; valid = '0;
    // requester 0 drops valid mid-busy
    valid = 2'b01;
    step();
    step();
    valid = 2'b00;
    step();
    rr = 1'b1;
    @(negedge clk) check("t6_ready_despite_drop", rdy, 2'b01);
    step();
    rr = 1'b0;
    check("t6_protocol_violations", viol, 1);
    // four requesters: completion by 2 moves priority to 3
    valid_b = 4'b0100; rr_b = 1'b1; rrd_b = 32'h3333_0000; addr_b = 32'h0C08_0400;
    step();
    @(negedge clk) check("t5_grant2", gnt_b, 4'b0100);
    step();
    valid_b = 4'b1010;
    step();
    @(negedge clk) check("t5_grant3", gnt_b, 4'b1000);
    check("t5_ready3", rdy_b, 4'b1000);
    check("t5_rd3", rd_b[127:96], 32'h3333_0000);
    check("t5_addr3", raddr_b, 8'h0C);
    step();
    step();
    @(negedge clk) check("t5_grant1", gnt_b, 4'b0010);
    check("t5_addr1", raddr_b, 8'h04);
    step();
    valid_b = '0; rr_b = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
